// File: rtl/fb_port_arbiter.sv
// Shares a single-port image RAM: video scan reads have absolute priority, CPU uses spare slots.
// Latency: video request -> vid_rgb exactly 3 cycles; CPU write ack grant+1, CPU read ack grant+3.
// Backpressure: none on video; CPU held off via cpu_req/cpu_ack until a slot without video is free.
module fb_port_arbiter #(
    parameter int IMG_W = 200,
    parameter int IMG_H = 200,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_valid,
    input  logic [9:0]    vid_x,
    input  logic [9:0]    vid_y,
    output logic [23:0]   vid_rgb,
    output logic          vid_rvalid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [23:0]   cpu_wdata,
    output logic          cpu_ack,
    output logic [23:0]   cpu_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [23:0]   mem_wdata,
    input  logic [23:0]   mem_rdata
);

    localparam logic [9:0]    X_LIM = 10'(IMG_W);
    localparam logic [9:0]    Y_LIM = 10'(IMG_H);
    localparam logic [AW-1:0] N_PIX = AW'(IMG_W * IMG_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_WR,
        S_ISSUE_RD,
        S_WAIT_RD,
        S_DONE_RD
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_grant;

    logic          w_vid_hit;
    logic [AW-1:0] w_vid_addr;
    logic          w_cpu_ok;

    logic          w_mem_en_d;
    logic          w_mem_we_d;
    logic [AW-1:0] w_mem_addr_d;
    logic [23:0]   w_mem_wdata_d;

    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [23:0]   r_mem_wdata;

    // Video valid and RAM-ownership tags: stage 1 aligns with mem_en, stage 2 with mem_rdata.
    logic          r_vid_v1;
    logic          r_vid_v2;
    logic          r_vid_hit1;
    logic          r_vid_hit2;
    logic          r_cpu_rd1;
    logic          r_cpu_rd2;

    logic [23:0]   r_vid_rgb;
    logic          r_vid_rvalid;
    logic          r_cpu_ack;
    logic [23:0]   r_cpu_rdata;

    // Area test and linear address are only meaningful inside the image, so no overflow there.
    assign w_vid_hit  = vid_valid && (vid_x < X_LIM) && (vid_y < Y_LIM);
    assign w_vid_addr = AW'(vid_y) * AW'(IMG_W) + AW'(vid_x);
    assign w_cpu_ok   = (cpu_addr < N_PIX);

    // CPU access sequencer: grant only from IDLE and only when video does not claim the next slot.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req && !w_vid_hit) begin
                    w_grant     = 1'b1;
                    w_state_nxt = cpu_we ? S_ISSUE_WR : S_ISSUE_RD;
                end
            end
            S_ISSUE_WR: w_state_nxt = S_IDLE;
            S_ISSUE_RD: w_state_nxt = S_WAIT_RD;
            S_WAIT_RD:  w_state_nxt = S_DONE_RD;
            S_DONE_RD:  w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Next RAM command: video owns the slot when it hits, otherwise a fresh CPU grant may use it.
    // Out-of-range CPU addresses still walk the sequencer but never touch the RAM.
    always_comb begin
        w_mem_en_d    = 1'b0;
        w_mem_we_d    = 1'b0;
        w_mem_addr_d  = '0;
        w_mem_wdata_d = '0;
        if (w_vid_hit) begin
            w_mem_en_d   = 1'b1;
            w_mem_addr_d = w_vid_addr;
        end else if (w_grant) begin
            w_mem_en_d    = w_cpu_ok;
            w_mem_we_d    = cpu_we && w_cpu_ok;
            w_mem_addr_d  = cpu_addr;
            w_mem_wdata_d = cpu_wdata;
        end
    end

    // State register, RAM command register and CPU response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rd1   <= 1'b0;
            r_cpu_rd2   <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_en    <= w_mem_en_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_wdata <= w_mem_wdata_d;
            r_cpu_rd1   <= w_grant && !cpu_we && w_cpu_ok;
            r_cpu_rd2   <= r_cpu_rd1;
            r_cpu_ack   <= (w_state_nxt == S_ISSUE_WR) || (w_state_nxt == S_DONE_RD);
            if (r_state == S_WAIT_RD) begin
                r_cpu_rdata <= r_cpu_rd2 ? mem_rdata : 24'h0;
            end
        end
    end

    // Fixed 3-stage video pipeline; returned data is taken only when the slot was a video read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vid_v1     <= 1'b0;
            r_vid_v2     <= 1'b0;
            r_vid_hit1   <= 1'b0;
            r_vid_hit2   <= 1'b0;
            r_vid_rvalid <= 1'b0;
            r_vid_rgb    <= '0;
        end else begin
            r_vid_v1     <= vid_valid;
            r_vid_v2     <= r_vid_v1;
            r_vid_hit1   <= w_vid_hit;
            r_vid_hit2   <= r_vid_hit1;
            r_vid_rvalid <= r_vid_v2;
            r_vid_rgb    <= r_vid_hit2 ? mem_rdata : 24'h0;
        end
    end

    assign vid_rgb    = r_vid_rgb;
    assign vid_rvalid = r_vid_rvalid;
    assign cpu_ack    = r_cpu_ack;
    assign cpu_rdata  = r_cpu_rdata;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: RAM model, per-cycle schedule-based reference model, directed tests.
// Latency: model predicts RAM commands at +1, video data at +3, CPU ack at +1 (write) / +3 (read).
// Backpressure: CPU agent holds cpu_req until it sees cpu_ack, then drops it the next cycle.
module tb_fb_port_arbiter;

    localparam int NPIX = 40000;

    logic        clk;
    logic        reset;
    logic        vid_valid;
    logic [9:0]  vid_x;
    logic [9:0]  vid_y;
    logic [23:0] vid_rgb;
    logic        vid_rvalid;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [23:0] cpu_wdata;
    logic        cpu_ack;
    logic [23:0] cpu_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    fb_port_arbiter #(.IMG_W(200), .IMG_H(200), .AW(16)) dut (
        .clk(clk), .reset(reset),
        .vid_valid(vid_valid), .vid_x(vid_x), .vid_y(vid_y),
        .vid_rgb(vid_rgb), .vid_rvalid(vid_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Image RAM seen by the DUT and the model's own view of what it must contain.
    logic [23:0] ram  [NPIX];
    logic [23:0] gold [NPIX];

    function automatic logic [23:0] pat(input int i);
        logic [31:0] v;
        v = (i * 32'd40503) ^ 32'h00A5C3;
        return v[23:0];
    endfunction

    always @(posedge clk) begin
        if (mem_en && (int'(mem_addr) < NPIX)) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expectations are scheduled by absolute cycle number.
    typedef struct {
        bit          en;
        bit          we;
        logic [15:0] addr;
        logic [23:0] wd;
    } memx_t;

    memx_t       exp_mem [int];
    bit          exp_vv  [int];
    logic [23:0] exp_rgb [int];
    bit          exp_ack [int];
    bit          exp_isrd[int];
    logic [23:0] exp_rd  [int];
    int          cyc;
    int          m_free;

    always @(negedge clk) begin
        bit          e_en;
        bit          hit;
        bit          ok;
        int          va;
        if (reset) begin
            cyc    = 0;
            m_free = 0;
            exp_mem.delete();
            exp_vv.delete();
            exp_rgb.delete();
            exp_ack.delete();
            exp_isrd.delete();
            exp_rd.delete();
        end else begin
            e_en = exp_mem.exists(cyc) ? exp_mem[cyc].en : 1'b0;
            chk("mem_en", mem_en, e_en);
            if (e_en) begin
                chk("mem_we", mem_we, exp_mem[cyc].we);
                chk("mem_addr", mem_addr, exp_mem[cyc].addr);
                if (exp_mem[cyc].we) chk("mem_wdata", mem_wdata, exp_mem[cyc].wd);
            end
            chk("vid_rvalid", vid_rvalid, exp_vv.exists(cyc) ? exp_vv[cyc] : 1'b0);
            chk("vid_rgb", vid_rgb, exp_rgb.exists(cyc) ? exp_rgb[cyc] : 24'h0);
            chk("cpu_ack", cpu_ack, exp_ack.exists(cyc) ? exp_ack[cyc] : 1'b0);
            if (exp_isrd.exists(cyc)) chk("cpu_rdata", cpu_rdata, exp_rd[cyc]);

            hit = vid_valid && (vid_x < 10'd200) && (vid_y < 10'd200);
            va  = int'(vid_y) * 200 + int'(vid_x);
            if (hit) exp_mem[cyc+1] = '{en: 1'b1, we: 1'b0, addr: 16'(va), wd: 24'h0};
            if (vid_valid) begin
                exp_vv[cyc+3]  = 1'b1;
                exp_rgb[cyc+3] = hit ? gold[va] : 24'h0;
            end
            if (cyc >= m_free && cpu_req && !hit) begin
                ok = int'(cpu_addr) < NPIX;
                exp_mem[cyc+1] = '{en: ok, we: cpu_we && ok, addr: cpu_addr, wd: cpu_wdata};
                if (cpu_we) begin
                    exp_ack[cyc+1] = 1'b1;
                    if (ok) gold[cpu_addr] = cpu_wdata;
                    m_free = cyc + 2;
                end else begin
                    exp_ack[cyc+3]  = 1'b1;
                    exp_isrd[cyc+3] = 1'b1;
                    exp_rd[cyc+3]   = ok ? gold[cpu_addr] : 24'h0;
                    m_free = cyc + 4;
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_cpu_ack"}, cpu_ack, 0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_vid_rgb"}, vid_rgb, 0);
        chk({tag, "_vid_rvalid"}, vid_rvalid, 0);
    endtask

    // lat = cycles from the cycle the request is first driven to the cycle cpu_ack is seen.
    task automatic cpu_access(input bit we, input logic [15:0] a, input logic [23:0] d,
                              output logic [23:0] rd, output int lat);
        bit got;
        got       = 1'b0;
        rd        = 24'h0;
        lat       = 0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                rd  = cpu_rdata;
                got = 1'b1;
                break;
            end
            lat++;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL cpu_ack_timeout: got no ack expected ack within 100 cycles addr %h", a);
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    logic [23:0] rd;
    int          lat;

    initial begin
        for (int i = 0; i < NPIX; i++) begin
            ram[i]  = pat(i);
            gold[i] = pat(i);
        end
        ram[205]    = 24'hABCDEF;
        gold[205]   = 24'hABCDEF;
        ram[39999]  = 24'h13579B;
        gold[39999] = 24'h13579B;
        mem_rdata   = 24'h0;

        reset     = 1'b1;
        vid_valid = 1'b0;
        vid_x     = '0;
        vid_y     = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        tick();
        tick();

        // In-area video read of (5,1) -> address 205.
        vid_valid = 1'b1; vid_x = 10'd5; vid_y = 10'd1;
        tick();
        chk("t2_mem_en", mem_en, 1);
        chk("t2_mem_addr", mem_addr, 205);
        vid_valid = 1'b0;
        tick();
        tick();
        chk("t2_vid_rvalid", vid_rvalid, 1);
        chk("t2_vid_rgb", vid_rgb, 24'hABCDEF);
        tick();

        // Out-of-area pixel: no RAM access, black pixel still emitted.
        vid_valid = 1'b1; vid_x = 10'd200; vid_y = 10'd0;
        tick();
        chk("t3_mem_en", mem_en, 0);
        vid_valid = 1'b0;
        tick();
        tick();
        chk("t3_vid_rvalid", vid_rvalid, 1);
        chk("t3_vid_rgb", vid_rgb, 0);
        tick();

        // CPU write contending with 10 in-area video cycles.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    vid_valid = 1'b1; vid_x = 10'(10 + i); vid_y = 10'd2;
                    tick();
                end
                vid_valid = 1'b0;
            end
            cpu_access(1'b1, 16'd7, 24'h123456, rd, lat);
        join
        chk("t4_wr_latency", lat, 11);
        tick();
        vid_valid = 1'b1; vid_x = 10'd7; vid_y = 10'd0;
        tick();
        vid_valid = 1'b0;
        tick();
        tick();
        chk("t4_readback_rgb", vid_rgb, 24'h123456);
        tick();

        // CPU reads in blanking: last pixel and one past the end.
        cpu_access(1'b0, 16'd39999, 24'h0, rd, lat);
        chk("t5_rd_latency", lat, 3);
        chk("t5_rd_data", rd, 24'h13579B);
        cpu_access(1'b0, 16'd40000, 24'h0, rd, lat);
        chk("t5_oob_latency", lat, 3);
        chk("t5_oob_data", rd, 0);
        cpu_access(1'b1, 16'd40000, 24'hFFFFFF, rd, lat);
        chk("t5_oob_wr_latency", lat, 1);
        cpu_access(1'b1, 16'd300, 24'h0A0B0C, rd, lat);
        chk("t5_wr_latency", lat, 1);
        cpu_access(1'b0, 16'd300, 24'h0, rd, lat);
        chk("t5_wr_readback", rd, 24'h0A0B0C);

        // Out-of-area pixel inside an in-area run gives the pending CPU read its slot.
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    vid_valid = 1'b1;
                    vid_x     = (i == 4) ? 10'd250 : ((i < 4) ? 10'(i) : 10'(i - 1));
                    vid_y     = 10'd3;
                    tick();
                end
                vid_valid = 1'b0;
            end
            cpu_access(1'b0, 16'd100, 24'h0, rd, lat);
        join
        chk("t6_rd_latency", lat, 7);
        chk("t6_rd_data", rd, pat(100));
        repeat (4) tick();

        // Reset in the middle of a CPU read drops the access.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd50;
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("t1_midreset");
        cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t1_no_ack_after_reset", cpu_ack, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
